glm_scan_driver: RTL and testbench
==================================

// Module: glm_scan_driver
// PURPOSE
//  Scan driver for the glm5va 1/8-scan HUB75 LED matrix. It replaces the fixed GLM_* pin levels with a real
//  row-pair refresh: it reads pixel pairs from a framebuffer RAM and shifts COLS columns out on GLM_R1..GLM_B2
//  with GLM_CLK. It then blanks, latches, selects the row on GLM_A/B/C and lights the row for a
//  brightness-controlled window. It sits between the framebuffer RAM (upstream) and the panel pins (downstream).
// PARAMETERS
//  COLS         32   columns per row pair; COL_BITS = $clog2(COLS)
//  CLK_DIV      2    clk cycles per GLM_CLK half-period (>=1)
//  DISP_CYCLES  256  clk cycles spent in DISPLAY per row (>=1)
// PORTS
//  clk          in   1          system clock
//  rst_n        in   1          asynchronous, active-low reset
//  enable       in   1          run refresh; sampled at row boundaries
//  brightness   in   8          OE-low cycles per row; sampled on entry to LATCH
//  fb_addr      out  3+COL_BITS {row[2:0], col}; framebuffer read address
//  fb_data      in   6          {B2,G2,R2,B1,G1,R1}; valid 1 clk after fb_addr
//  GLM_R1..B2   out  1 each     shift data, upper (1) and lower (2) half
//  GLM_A/B/C    out  1 each     row select, A = LSB
//  GLM_OE       out  1          output enable, active-low (1 = blanked)
//  GLM_LAT      out  1          latch strobe, active-high
//  GLM_CLK      out  1          shift clock; the panel samples on the rising edge
//  frame_start  out  1          1-clk pulse when the row-0 shift begins
// BEHAVIOUR
//  Reset (async): state=IDLE, row=0, col=0, fb_addr=0, colour outs=0, A/B/C=0, OE=1, LAT=0, CLK=0, frame_start=0.
//  All outputs are registered. No combinational path exists from any input to any output.
//  FSM states: IDLE, ADDR, DLOW, DHIGH, BLANK, LATCH, DISPLAY.
//  IDLE: OE=1, CLK=0. If enable=1 -> ADDR with col=0 and the current row.
//   frame_start pulses on this transition when row==0.
//  ADDR (1 clk): drive fb_addr={row,col}, CLK=0 -> DLOW.
//  DLOW (CLK_DIV clk): first cycle registers fb_data into the colour outs. CLK=0 throughout; data is held stable.
//  DHIGH (CLK_DIV clk): CLK=1 and data is held.
//   Exit: if col<COLS-1 then col++ -> ADDR. Otherwise -> BLANK.
//  Per column: 1+2*CLK_DIV clk, so a row shift takes COLS*(1+2*CLK_DIV) clk (160 at defaults).
//  BLANK (1 clk): OE=1, CLK=0 -> LATCH.
//  LATCH (CLK_DIV clk): LAT=1 and OE=1. {C,B,A}<=row in the first LATCH cycle. Samples brightness -> DISPLAY.
//  DISPLAY (DISP_CYCLES clk): LAT=0. OE=0 for the first min(brightness,DISP_CYCLES) cycles, then OE=1.
//   brightness=0 -> OE stays 1 for the whole state.
//   Exit: row<=row+1 mod 8 (7 wraps to 0). If enable=1 -> ADDR, pulsing frame_start if the new row==0.
//   If enable=0 -> IDLE with OE=1.
//  Row period = shift + 1 + CLK_DIV + DISP_CYCLES (419 clk at defaults); frame = 8 rows (3352 clk).
//  During ADDR/DLOW/DHIGH, OE=1: the previous row is dark while the next row shifts.
//  enable is ignored mid-row. Deassertion always completes the current row, including DISPLAY.
//  Colour outs hold their last value in BLANK/LATCH/DISPLAY/IDLE.
//  fb_data is ignored except in the first DLOW cycle. The RAM must have exactly 1-clk read latency.
//  Asserting rst_n low in any state returns every output to its reset value immediately.
//   Refresh restarts at row 0 with a frame_start pulse once enable is seen after reset.
//  brightness changes take effect only at the next LATCH. Values > DISP_CYCLES saturate.
// TESTING
//  T1 reset: rst_n=0 mid-DHIGH -> OE=1, CLK=0, LAT=0, A/B/C=0, fb_addr=0 in the same cycle.
//     After release with enable=1, frame_start pulses once and fb_addr=0.
//  T2 shift: FB model returns {B2..R1}=col[5:0]. Capture GLM_* on each CLK rise -> 32 rising edges per row.
//     Column k data equals k[5:0]; edges are 5 clk apart (CLK_DIV=2).
//  T3 latch/row: each LAT pulse is 2 clk wide with OE=1 throughout. A/B/C step 0,1..7,0.
//     LAT pulses are 419 clk apart. frame_start is 3352 clk apart.
//  T4 brightness: 100 -> OE low exactly 100 clk per row. 0 -> OE never low. 255 -> 255 low, 1 high in DISPLAY.
//     Changing brightness mid-DISPLAY affects only the next row.
//  T5 enable: drop enable during a row-3 shift -> row 3 completes through DISPLAY, then IDLE with OE=1.
//     Re-enable -> next shift is row 4 with no frame_start.
//  T6 CLK_DIV=1, COLS=16 rebuild: column period 3 clk, 16 CLK edges, row period 16*3+1+1+256=306 clk.

Source files
------------

// File: rtl/glm_scan_driver.sv
// HUB75 1/8-scan row-pair refresh: reads pixel pairs from a 1-clk-latency framebuffer RAM, shifts a
// row out on the GLM_* pins, latches it, then lights it for a brightness-controlled window.
module glm_scan_driver #(
  parameter int unsigned COLS        = 32,
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned DISP_CYCLES = 256,
  localparam int unsigned COL_BITS   = $clog2(COLS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [7:0]            brightness,
  output logic [3+COL_BITS-1:0] fb_addr,
  input  logic [5:0]            fb_data,
  output logic                  GLM_R1,
  output logic                  GLM_G1,
  output logic                  GLM_B1,
  output logic                  GLM_R2,
  output logic                  GLM_G2,
  output logic                  GLM_B2,
  output logic                  GLM_A,
  output logic                  GLM_B,
  output logic                  GLM_C,
  output logic                  GLM_OE,
  output logic                  GLM_LAT,
  output logic                  GLM_CLK,
  output logic                  frame_start
);

  localparam int unsigned CNT_MAX = (DISP_CYCLES > CLK_DIV) ? DISP_CYCLES : CLK_DIV;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]    DivLast  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]    DispLast = CNT_W'(DISP_CYCLES - 1);
  localparam logic [COL_BITS-1:0] ColLast  = COL_BITS'(COLS - 1);

  typedef enum logic [2:0] {
    StIdle, StAddr, StDlow, StDhigh, StBlank, StLatch, StDisplay
  } state_e;

  state_e              state;
  logic [2:0]          row;
  logic [COL_BITS-1:0] col;
  logic [CNT_W-1:0]    cnt;
  logic [7:0]          bright;
  logic [5:0]          rgb;
  logic [2:0]          sel;

  assign {GLM_B2, GLM_G2, GLM_R2, GLM_B1, GLM_G1, GLM_R1} = rgb;
  assign {GLM_C, GLM_B, GLM_A} = sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StIdle;
      row         <= '0;
      col         <= '0;
      cnt         <= '0;
      bright      <= '0;
      rgb         <= '0;
      sel         <= '0;
      fb_addr     <= '0;
      GLM_OE      <= 1'b1;
      GLM_LAT     <= 1'b0;
      GLM_CLK     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      unique case (state)
        StIdle: begin
          GLM_OE  <= 1'b1;
          GLM_CLK <= 1'b0;
          if (enable) begin
            state       <= StAddr;
            col         <= '0;
            fb_addr     <= {row, {COL_BITS{1'b0}}};
            frame_start <= (row == 3'd0);
          end
        end
        StAddr: begin
          state <= StDlow;
          cnt   <= '0;
        end
        StDlow: begin
          // RAM data for the address shown in ADDR is only valid in this first cycle
          if (cnt == '0) rgb <= fb_data;
          if (cnt == DivLast) begin
            state   <= StDhigh;
            cnt     <= '0;
            GLM_CLK <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StDhigh: begin
          if (cnt == DivLast) begin
            GLM_CLK <= 1'b0;
            cnt     <= '0;
            if (col != ColLast) begin
              col     <= col + 1'b1;
              fb_addr <= {row, col + 1'b1};
              state   <= StAddr;
            end else begin
              state <= StBlank;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StBlank: begin
          GLM_OE  <= 1'b1;
          GLM_LAT <= 1'b1;
          sel     <= row;
          bright  <= brightness;
          cnt     <= '0;
          state   <= StLatch;
        end
        StLatch: begin
          if (cnt == DivLast) begin
            GLM_LAT <= 1'b0;
            GLM_OE  <= (bright == 8'd0);
            cnt     <= '0;
            state   <= StDisplay;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StDisplay: begin
          if (cnt == DispLast) begin
            GLM_OE <= 1'b1;
            row    <= row + 3'd1;
            cnt    <= '0;
            if (enable) begin
              state       <= StAddr;
              col         <= '0;
              fb_addr     <= {row + 3'd1, {COL_BITS{1'b0}}};
              frame_start <= (row == 3'd7);
            end else begin
              state <= StIdle;
            end
          end else begin
            cnt <= cnt + 1'b1;
            // OE for the next cycle; brightness above DISP_CYCLES saturates naturally
            GLM_OE <= !((32'(cnt) + 32'd1) < 32'(bright));
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_glm_scan_driver.sv
// Scoreboard bench for glm_scan_driver: expected columns, row selects, OE windows and frame starts
// are queued up front and popped by monitors as the panel-side events appear.
module tb_glm_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n, enable, en_s;
  logic [7:0] brightness;

  logic [7:0] fb_addr;
  logic [5:0] fb_data;
  logic GLM_R1, GLM_G1, GLM_B1, GLM_R2, GLM_G2, GLM_B2;
  logic GLM_A, GLM_B, GLM_C, GLM_OE, GLM_LAT, GLM_CLK, frame_start;

  logic [6:0] s_addr;
  logic [5:0] s_fb;
  logic s_r1, s_g1, s_b1, s_r2, s_g2, s_b2, s_a, s_b, s_c, s_oe, s_lat, s_clk, s_fs;

  always #5 clk = ~clk;

  glm_scan_driver u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .brightness(brightness),
    .fb_addr(fb_addr), .fb_data(fb_data),
    .GLM_R1(GLM_R1), .GLM_G1(GLM_G1), .GLM_B1(GLM_B1),
    .GLM_R2(GLM_R2), .GLM_G2(GLM_G2), .GLM_B2(GLM_B2),
    .GLM_A(GLM_A), .GLM_B(GLM_B), .GLM_C(GLM_C),
    .GLM_OE(GLM_OE), .GLM_LAT(GLM_LAT), .GLM_CLK(GLM_CLK), .frame_start(frame_start)
  );

  glm_scan_driver #(.COLS(16), .CLK_DIV(1), .DISP_CYCLES(256)) u_small (
    .clk(clk), .rst_n(rst_n), .enable(en_s), .brightness(8'd50),
    .fb_addr(s_addr), .fb_data(s_fb),
    .GLM_R1(s_r1), .GLM_G1(s_g1), .GLM_B1(s_b1),
    .GLM_R2(s_r2), .GLM_G2(s_g2), .GLM_B2(s_b2),
    .GLM_A(s_a), .GLM_B(s_b), .GLM_C(s_c),
    .GLM_OE(s_oe), .GLM_LAT(s_lat), .GLM_CLK(s_clk), .frame_start(s_fs)
  );

  // Framebuffer models, 1-clk latency; data = col ^ (row << 3) so row mistakes show too
  always @(posedge clk) begin
    fb_data <= {1'b0, fb_addr[4:0]} ^ {fb_addr[7:5], 3'b000};
    s_fb    <= {2'b00, s_addr[3:0]} ^ {s_addr[6:4], 3'b000};
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic flag_fail(input string name);
    n_checks++;
    $display("FAIL %s: event with empty scoreboard queue (t=%0t)", name, $time);
  endtask

  logic [5:0] exp_col[$];
  logic [2:0] exp_row[$];
  int         exp_oe[$];
  int         exp_fs[$];

  bit   mon_en = 1'b0;
  bit   gap = 1'b0;
  bit   have_lat, have_fs, s_have_lat;
  int   cyc, last_rise, col_idx, last_lat, lat_w, disp_left, oe_low, lat_falls, fs_count, last_fs;
  int   s_cyc, s_last_rise, s_col, s_last_lat;
  logic [2:0] s_row;
  logic p_clk, p_lat, sp_clk, sp_lat;

  wire [5:0] data6   = {GLM_B2, GLM_G2, GLM_R2, GLM_B1, GLM_G1, GLM_R1};
  wire [5:0] s_data6 = {s_b2, s_g2, s_r2, s_b1, s_g1, s_r1};

  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      if (GLM_CLK && !p_clk) begin
        if (col_idx > 0) check("clk_spacing", cyc - last_rise, 5);
        if (exp_col.size() == 0) flag_fail("col_data");
        else check("col_data", int'(data6), int'(exp_col.pop_front()));
        col_idx++;
        last_rise = cyc;
      end
      if (GLM_LAT && !p_lat) begin
        check("cols_per_row", col_idx, 32);
        if (exp_row.size() == 0) flag_fail("row_sel");
        else check("row_sel", int'({GLM_C, GLM_B, GLM_A}), int'(exp_row.pop_front()));
        if (have_lat && !gap) check("row_period", cyc - last_lat, 419);
        gap = 1'b0;
        have_lat = 1'b1;
        last_lat = cyc;
        col_idx = 0;
        lat_w = 0;
      end
      if (GLM_LAT) begin
        lat_w++;
        check("oe_in_latch", int'(GLM_OE), 1);
      end
      if (!GLM_LAT && p_lat) begin
        check("lat_width", lat_w, 2);
        disp_left = 256;
        oe_low = 0;
        lat_falls++;
      end
      if (disp_left > 0) begin
        if (!GLM_OE) oe_low++;
        disp_left--;
        if (disp_left == 0) begin
          if (exp_oe.size() == 0) flag_fail("oe_low_cycles");
          else check("oe_low_cycles", oe_low, exp_oe.pop_front());
        end
      end
      if (frame_start) begin
        fs_count++;
        if (exp_fs.size() == 0) flag_fail("frame_start");
        else check("fs_addr", int'(fb_addr), exp_fs.pop_front());
        if (have_fs) check("frame_period", cyc - last_fs, 3352);
        have_fs = 1'b1;
        last_fs = cyc;
      end
    end
    p_clk = GLM_CLK;
    p_lat = GLM_LAT;
  end

  // Small build: column period 3, 16 columns, row period 306
  always @(negedge clk) begin
    if (mon_en) begin
      s_cyc++;
      if (s_clk && !sp_clk) begin
        if (s_col > 0) check("s_clk_spacing", s_cyc - s_last_rise, 3);
        check("s_col_data", int'(s_data6), int'(6'(s_col) ^ {s_row, 3'b000}));
        s_col++;
        s_last_rise = s_cyc;
      end
      if (s_lat && !sp_lat) begin
        check("s_cols_per_row", s_col, 16);
        check("s_row_sel", int'({s_c, s_b, s_a}), int'(s_row));
        if (s_have_lat) check("s_row_period", s_cyc - s_last_lat, 306);
        s_have_lat = 1'b1;
        s_last_lat = s_cyc;
        s_col = 0;
        s_row = s_row + 3'd1;
      end
    end
    sp_clk = s_clk;
    sp_lat = s_lat;
  end

  task automatic wait_falls(input int n);
    int b = 0;
    while (lat_falls < n && b < 5000) begin
      @(negedge clk);
      b++;
    end
    check("wait_display", (lat_falls >= n) ? 1 : 0, 1);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_oe"}, int'(GLM_OE), 1);
    check({tag, "_clk"}, int'(GLM_CLK), 0);
    check({tag, "_lat"}, int'(GLM_LAT), 0);
    check({tag, "_abc"}, int'({GLM_C, GLM_B, GLM_A}), 0);
    check({tag, "_fb_addr"}, int'(fb_addr), 0);
    check({tag, "_fs"}, int'(frame_start), 0);
    check({tag, "_rgb"}, int'(data6), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rows[14]   = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5};
    int brights[14] = '{100, 0, 255, 37, 37, 37, 37, 37, 37, 37, 37, 37, 37, 37};
    int rises, b, idle_oe, idle_clk;
    logic pc;

    rst_n = 1'b0;
    enable = 1'b0;
    en_s = 1'b0;
    brightness = 8'd100;
    repeat (2) @(negedge clk);
    check_reset_outs("por");

    // Run into the third column's DHIGH, then reset asynchronously mid-cycle
    rst_n = 1'b1;
    enable = 1'b1;
    rises = 0;
    b = 0;
    pc = 1'b0;
    while (rises < 3 && b < 100) begin
      @(negedge clk);
      if (GLM_CLK && !pc) rises++;
      pc = GLM_CLK;
      b++;
    end
    check("reach_dhigh", rises, 3);
    check("pre_reset_fb_addr", int'(fb_addr), 2);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("async");
    repeat (2) @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < 32; k++) exp_col.push_back(6'(k) ^ {3'(rows[i]), 3'b000});
      exp_row.push_back(3'(rows[i]));
      exp_oe.push_back(brights[i]);
    end
    exp_fs.push_back(0);
    exp_fs.push_back(0);

    cyc = 0; col_idx = 0; lat_falls = 0; fs_count = 0; disp_left = 0;
    have_lat = 1'b0; have_fs = 1'b0;
    s_cyc = 0; s_col = 0; s_row = 3'd0; s_have_lat = 1'b0;
    mon_en = 1'b1;
    en_s = 1'b1;
    rst_n = 1'b1;

    // Mid-DISPLAY brightness changes must only affect the following row
    wait_falls(1);
    repeat (50) @(negedge clk);
    brightness = 8'd0;
    wait_falls(2);
    repeat (50) @(negedge clk);
    brightness = 8'd255;
    wait_falls(3);
    repeat (50) @(negedge clk);
    brightness = 8'd37;

    // Drop enable during the second frame's row-3 shift; the row must still complete
    wait_falls(11);
    repeat (296) @(negedge clk);
    enable = 1'b0;
    wait_falls(12);
    repeat (262) @(negedge clk);
    gap = 1'b1;
    idle_oe = 0;
    idle_clk = 0;
    repeat (100) begin
      @(negedge clk);
      if (!GLM_OE) idle_oe++;
      if (GLM_CLK) idle_clk++;
    end
    check("idle_oe_low", idle_oe, 0);
    check("idle_clk_high", idle_clk, 0);
    enable = 1'b1;

    wait_falls(14);
    repeat (20) @(negedge clk);
    enable = 1'b0;
    repeat (300) @(negedge clk);

    check("cols_left", exp_col.size(), 0);
    check("rows_left", exp_row.size(), 0);
    check("oe_left", exp_oe.size(), 0);
    check("fs_left", exp_fs.size(), 0);
    check("fs_count", fs_count, 2);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
